// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------------------------------------------------------------------
// Sequencing and arbitration controller for the byte-addressed 256x8 RAM.
// Arbitrates round-robin between the instruction-fetch port (if_*) and the
// datapath load/store port (d_*), serves one access at a time through the
// RAM level handshake (enable/rw/size/sign until MOC), and returns registered
// read data plus a fault flag with a one-cycle ready pulse to the grantee.
// An access whose MOC does not arrive within TIMEOUT wait cycles is aborted
// with fault=1 and rdata=0.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   if_req_i, if_addr_i   fetch request (level) and byte address
//   if_ready_o/rdata_o/fault_o  fetch completion pulse, word, fault
//   d_req_i, d_rw_i, d_size_i, d_sign_i, d_addr_i, d_wdata_i  data request
//   d_ready_o/rdata_o/fault_o   data completion pulse, load data, fault
//   mem_enable_o .. mem_wdata_o RAM Enable/ReadWrite/Size/Sign/Address/DataIn
//   mem_rdata_i, mem_moc_i      RAM DataOut and MOC
//   busy_o                      controller is not idle
//
// Configuration
//   MEM_ALIGN_CHECK_EN  when defined, misaligned accesses (size 3, odd
//                       halfword, non-word-aligned word) are faulted
//                       directly from IDLE without touching the RAM.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  output logic        if_fault_o,
  input  logic        d_req_i,
  input  logic        d_rw_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_sign_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic        d_fault_o,
  output logic        mem_enable_o,
  output logic        mem_rw_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_sign_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_moc_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);
  localparam logic       GRANT_FETCH = 1'b0;
  localparam logic       GRANT_DATA  = 1'b1;

`ifdef MEM_ALIGN_CHECK_EN
  // Size 3 is never legal; halfwords need an even address, words a
  // multiple of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction
`endif

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        mem_enable_q, mem_enable_d;
  logic        mem_rw_q, mem_rw_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_sign_q, mem_sign_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_fault_q, if_fault_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_fault_q, d_fault_d;
  logic        busy_q, busy_d;

  logic        pick_data_s;
  logic        pick_fetch_s;
  logic        finish_s;
  logic        fault_s;
  logic [31:0] rdata_s;
  logic [7:0]  timer_inc_s;

  // On a tie the requester that did not win last time gets the RAM.
  assign pick_data_s  = d_req_i & (~if_req_i | (last_grant_q == GRANT_FETCH));
  assign pick_fetch_s = if_req_i & ~pick_data_s;
  // Saturating increment: the timer parks at 255 instead of wrapping.
  assign timer_inc_s  = (timer_q == 8'hFF) ? timer_q : (timer_q + 8'd1);

  // Next-state, field latching and completion-result logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_rw_d     = mem_rw_q;
    mem_size_d   = mem_size_q;
    mem_sign_d   = mem_sign_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ready_d   = 1'b0;
    if_rdata_d   = 32'd0;
    if_fault_d   = 1'b0;
    d_ready_d    = 1'b0;
    d_rdata_d    = 32'd0;
    d_fault_d    = 1'b0;
    finish_s     = 1'b0;
    fault_s      = 1'b0;
    rdata_s      = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (pick_data_s || pick_fetch_s) begin
          grant_d = pick_data_s;
          if (pick_data_s) begin
            mem_rw_d    = d_rw_i;
            mem_size_d  = d_size_i;
            mem_sign_d  = d_sign_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            // Fetches are always unsigned word reads.
            mem_rw_d    = 1'b1;
            mem_size_d  = 2'd2;
            mem_sign_d  = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = 32'd0;
          end
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned(mem_size_d, mem_addr_d[1:0])) begin
            state_d  = ST_RELEASE;
            finish_s = 1'b1;
            fault_s  = 1'b1;
          end else begin
            state_d  = ST_SETUP;
          end
`else
          state_d = ST_SETUP;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_moc_i) begin
          state_d  = ST_RELEASE;
          finish_s = 1'b1;
          fault_s  = 1'b0;
          // Stores report zero data.
          rdata_s  = mem_rw_q ? mem_rdata_i : 32'd0;
        end else begin
          timer_d = timer_inc_s;
          if (timer_inc_s == TIMEOUT_C) begin
            state_d  = ST_RELEASE;
            finish_s = 1'b1;
            fault_s  = 1'b1;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end
      ST_RELEASE: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Route the completion to the grantee only; the other port stays quiet.
    if (finish_s) begin
      if (grant_d == GRANT_DATA) begin
        d_ready_d  = 1'b1;
        d_rdata_d  = rdata_s;
        d_fault_d  = fault_s;
      end else begin
        if_ready_d = 1'b1;
        if_rdata_d = rdata_s;
        if_fault_d = fault_s;
      end
    end else begin
      if_ready_d = 1'b0;
      d_ready_d  = 1'b0;
    end

    mem_enable_d = (state_d == ST_WAIT);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= 8'd0;
      last_grant_q <= GRANT_FETCH;
      grant_q      <= GRANT_FETCH;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_size_q   <= 2'd0;
      mem_sign_q   <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= 32'd0;
      if_fault_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      d_rdata_q    <= 32'd0;
      d_fault_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_size_q   <= mem_size_d;
      mem_sign_q   <= mem_sign_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      if_fault_q   <= if_fault_d;
      d_ready_q    <= d_ready_d;
      d_rdata_q    <= d_rdata_d;
      d_fault_q    <= d_fault_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ready_o   = if_ready_q;
  assign if_rdata_o   = if_rdata_q;
  assign if_fault_o   = if_fault_q;
  assign d_ready_o    = d_ready_q;
  assign d_rdata_o    = d_rdata_q;
  assign d_fault_o    = d_fault_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_rw_o     = mem_rw_q;
  assign mem_size_o   = mem_size_q;
  assign mem_sign_o   = mem_sign_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a behavioural 256x8 big-endian RAM with
// switchable MOC, a table of single accesses checked through an expectation
// queue, plus hand-written arbitration and reset-in-flight sequences.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_size;
  logic        d_sign;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_fault;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_moc;
  logic        busy;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_ready_o(if_ready), .if_rdata_o(if_rdata), .if_fault_o(if_fault),
    .d_req_i(d_req), .d_rw_i(d_rw), .d_size_i(d_size), .d_sign_i(d_sign),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ready_o(d_ready), .d_rdata_o(d_rdata), .d_fault_o(d_fault),
    .mem_enable_o(mem_enable), .mem_rw_o(mem_rw), .mem_size_o(mem_size),
    .mem_sign_o(mem_sign), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_moc_i(mem_moc), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, big-endian: byte at addr is the most significant.
  logic [7:0] ram [0:255];
  logic       moc_en;
  logic [7:0] ra;

  assign mem_moc = mem_enable & moc_en;

  always_comb begin
    ra = mem_addr[7:0];
    case (mem_size)
      2'd0:    mem_rdata = mem_sign ? {{24{ram[ra][7]}}, ram[ra]} : {24'd0, ram[ra]};
      2'd1:    mem_rdata = mem_sign ? {{16{ram[ra][7]}}, ram[ra], ram[ra + 8'd1]}
                                    : {16'd0, ram[ra], ram[ra + 8'd1]};
      default: mem_rdata = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};
    endcase
  end

  typedef struct {
    logic        d;
    logic        rw;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        moc;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          en;
  } vec_t;

  typedef struct {
    logic        d;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   pass_cnt;
  int   total_cnt;
  int   en_cnt;
  int   rdy_cnt;
  int   lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
  endtask

  // One sampling cycle: RAM write-back, enable counting and scoreboard pop.
  task automatic tick();
    exp_t e;
    logic [7:0] a;
    @(negedge clk);
    lat++;
    if (mem_enable) en_cnt++;
    if (mem_enable && mem_moc && !mem_rw) begin
      a = mem_addr[7:0];
      case (mem_size)
        2'd0: ram[a] = mem_wdata[7:0];
        2'd1: begin ram[a] = mem_wdata[15:8]; ram[a + 8'd1] = mem_wdata[7:0]; end
        default: begin
          ram[a] = mem_wdata[31:24];        ram[a + 8'd1] = mem_wdata[23:16];
          ram[a + 8'd2] = mem_wdata[15:8];  ram[a + 8'd3] = mem_wdata[7:0];
        end
      endcase
    end
    if (if_ready || d_ready) begin
      rdy_cnt++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_ready: actual if_ready=%0b d_ready=%0b required none", if_ready, d_ready);
      end else begin
        e = exp_q.pop_front();
        chk("both_ready", {31'd0, if_ready & d_ready}, 32'd0);
        chk("who", {31'd0, d_ready}, {31'd0, e.d});
        chk("rdata", e.d ? d_rdata : if_rdata, e.rdata);
        chk("fault", {31'd0, e.d ? d_fault : if_fault}, {31'd0, e.fault});
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   start;
    v = vecs[idx];
    @(posedge clk); #1;
    moc_en = v.moc;
    if (v.d) begin
      d_req = 1'b1; d_rw = v.rw; d_size = v.sz; d_sign = v.sg;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    exp_q.push_back('{d: v.d, rdata: v.rdata, fault: v.fault});
    lat = 0; en_cnt = 0; start = rdy_cnt;
    while (rdy_cnt == start && lat < 64) tick();
    if (rdy_cnt == start) $display("FAIL vec%0d_no_ready: actual none required ready", idx);
    chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.lat));
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;
    chk($sformatf("vec%0d_enable_cycles", idx), 32'(en_cnt), 32'(v.en));
    if (v.en != 0) chk($sformatf("vec%0d_mem_addr", idx), mem_addr, v.addr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick(); tick();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; en_cnt = 0; rdy_cnt = 0; lat = 0;
    rst_n = 1'b0; moc_en = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_rw = 1'b0; d_size = 2'd0; d_sign = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[0] = 8'h12; ram[1] = 8'h34; ram[2] = 8'h56; ram[3] = 8'h78;
    ram[16] = 8'hFF; ram[17] = 8'h80;

    //            d     rw    sz    sg    addr      wdata          moc   rdata          flt   lat en
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'd0,         1'b1, 32'h12345678, 1'b0, 4,  1};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 1'b1, 32'h10, 32'd0,         1'b1, 32'hFFFFFF80, 1'b0, 4,  1};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h10, 32'd0,         1'b1, 32'h0000FF80, 1'b0, 4,  1};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 1'b1, 32'h11, 32'd0,         1'b1, 32'hFFFFFF80, 1'b0, 4,  1};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, 4,  1};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'd0,         1'b1, 32'hDEADBEEF, 1'b0, 4,  1};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'd0,         1'b1, 32'h5E5F5C5D, 1'b0, 4,  1};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h08, 32'd0,         1'b0, 32'h00000000, 1'b1, 19, 16};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h01, 32'd0,         1'b1, 32'h00000034, 1'b0, 4,  1};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h22, 32'd0,         1'b1, 32'h00000000, 1'b1, 2,  0};
`else
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h22, 32'd0,         1'b1, 32'hBEEF7E7F, 1'b0, 4,  1};
`endif
    vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h30, 32'h000000AB, 1'b1, 32'h00000000, 1'b0, 4,  1};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h30, 32'd0,         1'b1, 32'h000000AB, 1'b0, 4,  1};

    // Reset state.
    tick(); tick(); tick();
    chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Both requesters held from reset: data, fetch, data, fetch back to back.
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'd0; d_sign = 1'b0; d_addr = 32'h1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{d: 1'b1, rdata: 32'h00000034, fault: 1'b0});
      exp_q.push_back('{d: 1'b0, rdata: 32'h12345678, fault: 1'b0});
    end
    lat = 0; rdy_cnt = 0;
    while (rdy_cnt < 4 && lat < 64) tick();
    chk("arb_ready_count", 32'(rdy_cnt), 32'd4);
    chk("arb_back_to_back", 32'(lat), 32'd16);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    chk("arb_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while an access sits in WAIT; the held request is served again.
    @(posedge clk); #1;
    moc_en = 1'b0;
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'd2; d_sign = 1'b0; d_addr = 32'h0;
    tick(); tick(); tick();
    chk("inflight_enable", {31'd0, mem_enable}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_wait_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    chk("rst_wait_no_ready", {31'd0, d_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; moc_en = 1'b1;
    exp_q.push_back('{d: 1'b1, rdata: 32'h12345678, fault: 1'b0});
    lat = 0; rdy_cnt = 0;
    while (rdy_cnt == 0 && lat < 64) tick();
    chk("rst_reserviced", 32'(rdy_cnt), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    tick(); tick();
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing and arbitration controller for the byte-addressed 256x8 data/instruction RAM. It accepts word fetches from the instruction-fetch unit and load/store requests from the datapath, grants one at a time round-robin, and drives the RAM's level handshake (Enable/ReadWrite/Size/Sign) until MOC. It registers read data back to the winning requester and flags accesses that never complete within a bounded timeout.

## Interface
- TIMEOUT, 16, WAIT cycles without MOC before the access is aborted (legal 1..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, level; held with if_addr stable until if_ready
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word, valid while if_ready=1
- if_fault  out  1  timeout/alignment fault, valid while if_ready=1
- d_req  in  1  data request, level; held with d_* fields stable until d_ready
- d_rw  in  1  1=load, 0=store (RAM ReadWrite convention)
- d_size  in  2  0=byte, 1=halfword, 2=word
- d_sign  in  1  sign-extend load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle completion pulse
- d_rdata  out  32  load data, valid while d_ready=1 (0 for stores)
- d_fault  out  1  fault, valid while d_ready=1
- mem_enable  out  1  RAM Enable
- mem_rw  out  1  RAM ReadWrite
- mem_size  out  2  RAM Size
- mem_sign  out  1  RAM Sign
- mem_addr  out  32  RAM Address
- mem_wdata  out  32  RAM DataIn
- mem_rdata  in  32  RAM DataOut
- mem_moc  in  1  RAM MOC
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SETUP, WAIT, RELEASE.
- IDLE: if neither req, stay. If one req, grant it. If both, grant the requester not granted last (last_grant register; reset value = fetch, so data wins the first tie). Latch mem_rw/size/sign/addr/wdata from grantee; fetch always drives rw=1, size=2, sign=0, wdata=0. Go SETUP.
- SETUP: mem_enable=0, fields stable one full cycle. Clear timer. Go WAIT.
- WAIT: mem_enable=1. If mem_moc=1 at the edge: capture mem_rdata (loads) into grantee rdata, fault=0, go RELEASE. Else timer+1; when timer reaches TIMEOUT: rdata=0, fault=1, go RELEASE.
- RELEASE: mem_enable=0; grantee ready=1 for this cycle only with rdata/fault; update last_grant; go IDLE. Non-granted ready stays 0.
- mem_* fields hold last values between accesses; only mem_enable toggles the RAM.
- Timer is 8 bits, saturating; never wraps.
- Requester dropping req mid-access: access still completes, ready still pulsed.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, all outputs 0 (mem_enable, ready, fault, rdata, mem_* fields), timer=0, last_grant=fetch. An in-flight access is abandoned with no ready pulse; mem_enable drops at that edge.
- Request sampled at edge E0 in IDLE → SETUP after E0 → WAIT after E1 → earliest MOC sample at E2 → ready high E2..E3 → IDLE after E3. Minimum 4 cycles from request to ready cycle end; back-to-back accesses every 4 cycles.
- Timeout: ready high exactly TIMEOUT+1 cycles after entering WAIT... precisely, WAIT lasts TIMEOUT cycles, then RELEASE.
- MOC sampled only in WAIT; MOC in other states ignored.
- Requester must deassert or change req on the edge ending its ready cycle; a still-asserted req in the following IDLE is a new request.

## Configuration
- MEM_ALIGN_CHECK_EN defined: in IDLE, a grantee with size=3, size=1 and addr[0]=1, or size=2 and addr[1:0]!=0 skips SETUP/WAIT, goes straight to RELEASE with fault=1, rdata=0; mem_enable never asserts; latency 2 cycles. Applies to fetches (word) too.
- Undefined: no check; all accesses issued unchanged (RAM applies its own store realignment).

## Test plan
- Single fetch, RAM bytes 0x00..0x03 = 12 34 56 78, if_addr=0, MOC immediate → if_ready in 4th cycle, if_rdata=0x12345678, if_fault=0, mem_enable high exactly 1 cycle.
- Simultaneous if_req and d_req held continuously after reset → grants data, fetch, data, fetch alternately; each ready pulse exactly one cycle.
- Signed halfword load from 0x10 holding 0xFF80 → d_rdata=0xFFFFFF80; store word 0xDEADBEEF to 0x20 then word load 0x20 → 0xDEADBEEF, d_rdata=0 on the store's ready.
- MOC tied 0, TIMEOUT=16, d_req load → d_ready with d_fault=1, d_rdata=0, mem_enable high exactly 16 cycles, then controller serves next request normally.
- rst_n low during WAIT → next cycle mem_enable=0, busy=0, no ready pulse; request held afterward is re-serviced from IDLE.
- With MEM_ALIGN_CHECK_EN, word load at 0x22 → d_fault=1 two cycles after request, mem_enable never asserted; without macro same request issues to RAM.
